// File: rtl/bs_job_scheduler_if.sv
// Request, pricer and result signal bundle for bs_job_scheduler.
// slave = scheduler view; master = requester / pricer / consumer view.
interface bs_job_scheduler_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [TAG_W-1:0] req_tag;
  logic [WIDTH-1:0] req_S0, req_K, req_T, req_sigma, req_r;
  logic             req_otype;

  logic             pr_start;
  logic [WIDTH-1:0] pr_S0, pr_K, pr_T, pr_sigma, pr_r;
  logic             pr_otype;
  logic             pr_flush;
  logic             pr_done;
  logic [WIDTH-1:0] pr_price;

  logic             res_valid;
  logic             res_ready;
  logic [TAG_W-1:0] res_tag;
  logic [WIDTH-1:0] res_price;
  logic [1:0]       res_err;

  modport slave (
    input  req_valid, req_tag, req_S0, req_K, req_T, req_sigma, req_r, req_otype,
    output req_ready,
    output pr_start, pr_S0, pr_K, pr_T, pr_sigma, pr_r, pr_otype, pr_flush,
    input  pr_done, pr_price,
    output res_valid, res_tag, res_price, res_err,
    input  res_ready
  );

  modport master (
    output req_valid, req_tag, req_S0, req_K, req_T, req_sigma, req_r, req_otype,
    input  req_ready,
    input  pr_start, pr_S0, pr_K, pr_T, pr_sigma, pr_r, pr_otype, pr_flush,
    output pr_done, pr_price,
    input  res_valid, res_tag, res_price, res_err,
    output res_ready
  );
endinterface

// File: rtl/bs_job_scheduler.sv
// Job FIFO + single-job sequencer in front of the Black-Scholes pricer.
// Optional WAIT watchdog with pricer flush: define BS_SCHED_TIMEOUT_EN.
module bs_job_scheduler #(
  parameter int WIDTH          = 32,
  parameter int TAG_W          = 4,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                     clk,
  input  logic                     reset,
  bs_job_scheduler_if.slave        bus,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_INVALID = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] s0, k, t, sigma, r;
    logic             otype;
  } job_t;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESULT} state_t;

  job_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop;
  job_t          head;
  logic          head_ok;
  logic          timeout_hit;
  state_t        state, state_nxt;

  assign full          = (count == (AW+1)'(DEPTH));
  assign empty         = (count == '0);
  assign bus.req_ready = !reset && !full;
  assign push          = bus.req_valid && bus.req_ready;
  assign head          = mem[rd_ptr];
  // r may take any sign; the other four operands must be strictly positive.
  assign head_ok       = ($signed(head.s0) > 0) && ($signed(head.k) > 0) &&
                         ($signed(head.t) > 0) && ($signed(head.sigma) > 0);
  assign busy          = (state != IDLE) || !empty;
  assign fifo_count    = count;

  // NOTE: the storage array has no reset; an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= '{bus.req_tag, bus.req_S0, bus.req_K, bus.req_T,
                       bus.req_sigma, bus.req_r, bus.req_otype};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

`ifdef BS_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wd_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              wd_cnt <= '0;
    else if (state != WAIT) wd_cnt <= '0;
    else                    wd_cnt <= wd_cnt + TW'(1);
  end

  // wd_cnt is 0 in the first WAIT cycle, so this fires in the TIMEOUT_CYCLES-th one.
  assign timeout_hit = (state == WAIT) && (wd_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt     = state;
    pop           = 1'b0;
    bus.pr_start  = 1'b0;
    bus.pr_flush  = 1'b0;
    bus.res_valid = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = head_ok ? LAUNCH : RESULT;
        end
      end
      LAUNCH: begin
        bus.pr_start = 1'b1;
        state_nxt    = WAIT;
      end
      WAIT: begin
        if (bus.pr_done) begin
          state_nxt = RESULT;
        end else if (timeout_hit) begin
          bus.pr_flush = 1'b1;
          state_nxt    = RESULT;
        end
      end
      RESULT: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are loaded only for valid jobs, leaving the pricer untouched by rejected ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.pr_S0     <= '0;
      bus.pr_K      <= '0;
      bus.pr_T      <= '0;
      bus.pr_sigma  <= '0;
      bus.pr_r      <= '0;
      bus.pr_otype  <= 1'b0;
      bus.res_tag   <= '0;
      bus.res_price <= '0;
      bus.res_err   <= ERR_OK;
    end else begin
      if (pop) begin
        bus.res_tag   <= head.tag;
        bus.res_price <= '0;
        bus.res_err   <= head_ok ? ERR_OK : ERR_INVALID;
        if (head_ok) begin
          bus.pr_S0    <= head.s0;
          bus.pr_K     <= head.k;
          bus.pr_T     <= head.t;
          bus.pr_sigma <= head.sigma;
          bus.pr_r     <= head.r;
          bus.pr_otype <= head.otype;
        end
      end
      if (state == WAIT) begin
        if (bus.pr_done) begin
          bus.res_price <= bus.pr_price;
          bus.res_err   <= ERR_OK;
        end else if (timeout_hit) begin
          bus.res_price <= '0;
          bus.res_err   <= ERR_TIMEOUT;
        end
      end
    end
  end
endmodule
